// File: rtl/bus_decoder_pkg.sv
// Shared AlgolSoC bus definitions: decoder FSM states and default slave address map.
package bus_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Default address map; the linker map and software headers track these values.
  localparam logic [31:0] RAM_BASE   = 32'h8000_0000;
  localparam logic [31:0] RAM_MASK   = 32'hF000_0000;
  localparam logic [31:0] TIMER_BASE = 32'h0200_0000;
  localparam logic [31:0] TIMER_MASK = 32'hFFFF_FFF0;
  localparam logic [31:0] UART_BASE  = 32'h1000_0000;
  localparam logic [31:0] UART_MASK  = 32'hFFFF_FF00;

endpackage

// File: rtl/bus_addr_match.sv
// Single-window address comparator: hit when the masked address equals the masked base.
module bus_addr_match
  import bus_decoder_pkg::*;
#(
  parameter logic [31:0] BASE = RAM_BASE,
  parameter logic [31:0] MASK = RAM_MASK
) (
  input  logic [31:0] address,
  output logic        hit
);

  assign hit = ((address & MASK) == (BASE & MASK));

endmodule

// File: rtl/bus_decoder.sv
// Single-master to three-slave bus decoder with error termination of unmapped and hung accesses.
module bus_decoder
  import bus_decoder_pkg::*;
#(
  parameter logic [31:0] SLAVE0_BASE = RAM_BASE,
  parameter logic [31:0] SLAVE0_MASK = RAM_MASK,
  parameter logic [31:0] SLAVE1_BASE = TIMER_BASE,
  parameter logic [31:0] SLAVE1_MASK = TIMER_MASK,
  parameter logic [31:0] SLAVE2_BASE = UART_BASE,
  parameter logic [31:0] SLAVE2_MASK = UART_MASK,
  parameter int          TIMEOUT     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] m_address,
  input  logic [31:0] m_wdata,
  input  logic [3:0]  m_wsel,
  input  logic        m_valid,
  output logic [31:0] m_rdata,
  output logic        m_ready,
  output logic        m_error,
  output logic [31:0] s_address,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wsel,
  output logic [2:0]  s_valid,
  input  logic [95:0] s_rdata,
  input  logic [2:0]  s_ready,
  input  logic [2:0]  s_error
);

  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       s_valid_q, s_valid_d;
  logic [31:0]      s_address_q, s_address_d;
  logic [31:0]      s_wdata_q, s_wdata_d;
  logic [3:0]       s_wsel_q, s_wsel_d;
  logic             m_ready_q, m_ready_d;
  logic             m_error_q, m_error_d;
  logic [31:0]      m_rdata_q, m_rdata_d;

  logic [2:0]       hit;
  logic             any_hit;
  logic [1:0]       hit_sel;
  logic [31:0]      sel_rdata;
  logic             sel_ready;
  logic             sel_error;

  bus_addr_match #(.BASE(SLAVE0_BASE), .MASK(SLAVE0_MASK)) u_match0 (.address(m_address), .hit(hit[0]));
  bus_addr_match #(.BASE(SLAVE1_BASE), .MASK(SLAVE1_MASK)) u_match1 (.address(m_address), .hit(hit[1]));
  bus_addr_match #(.BASE(SLAVE2_BASE), .MASK(SLAVE2_MASK)) u_match2 (.address(m_address), .hit(hit[2]));

  // Fixed-priority encode of the window hits: slave 0 wins over 1, 1 over 2.
  always_comb begin
    any_hit = |hit;
    hit_sel = 2'd0;
    if (hit[0])      hit_sel = 2'd0;
    else if (hit[1]) hit_sel = 2'd1;
    else if (hit[2]) hit_sel = 2'd2;
  end

  // Route only the selected slave's response; the other slaves are never looked at.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_error = 1'b0;
    case (sel_q)
      2'd0: begin sel_rdata = s_rdata[31:0];  sel_ready = s_ready[0]; sel_error = s_error[0]; end
      2'd1: begin sel_rdata = s_rdata[63:32]; sel_ready = s_ready[1]; sel_error = s_error[1]; end
      2'd2: begin sel_rdata = s_rdata[95:64]; sel_ready = s_ready[2]; sel_error = s_error[2]; end
      default: ;
    endcase
  end

  // Next-state logic; every output is computed here and registered below.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    s_valid_d   = s_valid_q;
    s_address_d = s_address_q;
    s_wdata_d   = s_wdata_q;
    s_wsel_d    = s_wsel_q;
    m_ready_d   = 1'b0;
    m_error_d   = m_error_q;
    m_rdata_d   = m_rdata_q;
    case (state_q)
      IDLE: begin
        if (m_valid) begin
          if (any_hit) begin
            s_address_d = m_address;
            s_wdata_d   = m_wdata;
            s_wsel_d    = m_wsel;
            sel_d       = hit_sel;
            s_valid_d   = 3'b001 << hit_sel;
            cnt_d       = '0;
            state_d     = WAIT;
          end else begin
            m_ready_d = 1'b1;
            m_error_d = 1'b1;
            m_rdata_d = '0;
            state_d   = DONE;
          end
        end
      end
      WAIT: begin
        if (sel_ready) begin
          s_valid_d = '0;
          m_ready_d = 1'b1;
          m_error_d = sel_error;
          m_rdata_d = sel_rdata;
          state_d   = DONE;
        end else if (cnt_q == CNT_LAST) begin
          s_valid_d = '0;
          m_ready_d = 1'b1;
          m_error_d = 1'b1;
          m_rdata_d = '0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        // s_valid is already low here, so a registered-ready slave cannot accept twice.
        s_valid_d = '0;
        state_d   = IDLE;
      end
      default: begin
        s_valid_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 2'd0;
      cnt_q       <= '0;
      s_valid_q   <= '0;
      s_address_q <= '0;
      s_wdata_q   <= '0;
      s_wsel_q    <= '0;
      m_ready_q   <= 1'b0;
      m_error_q   <= 1'b0;
      m_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      s_valid_q   <= s_valid_d;
      s_address_q <= s_address_d;
      s_wdata_q   <= s_wdata_d;
      s_wsel_q    <= s_wsel_d;
      m_ready_q   <= m_ready_d;
      m_error_q   <= m_error_d;
      m_rdata_q   <= m_rdata_d;
    end
  end

  assign m_rdata   = m_rdata_q;
  assign m_ready   = m_ready_q;
  assign m_error   = m_error_q;
  assign s_address = s_address_q;
  assign s_wdata   = s_wdata_q;
  assign s_wsel    = s_wsel_q;
  assign s_valid   = s_valid_q;

endmodule

// File: tb/tb_bus_decoder.sv
// Testbench for bus_decoder: directed vector table, reset-in-flight sequence, random traffic.
module tb_bus_decoder;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst_n;
  logic [31:0] m_address, m_wdata, m_rdata, s_address, s_wdata;
  logic [3:0]  m_wsel, s_wsel;
  logic        m_valid, m_ready, m_error;
  logic [2:0]  s_valid, s_ready, s_error;
  logic [95:0] s_rdata;

  int checks = 0;
  int errors = 0;

  bus_decoder #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_address(m_address), .m_wdata(m_wdata), .m_wsel(m_wsel), .m_valid(m_valid),
    .m_rdata(m_rdata), .m_ready(m_ready), .m_error(m_error),
    .s_address(s_address), .s_wdata(s_wdata), .s_wsel(s_wsel), .s_valid(s_valid),
    .s_rdata(s_rdata), .s_ready(s_ready), .s_error(s_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wsel;
    int          delay;
    logic [31:0] rdata;
    logic        err;
    bit          spur;
    int          exp_lat;
    int          exp_v;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Address map from the memory map: RAM 0x8xxx_xxxx, timer 16 bytes, UART 256 bytes.
  function automatic int decode(input logic [31:0] a);
    if (a[31:28] == 4'h8)        return 0;
    if (a[31:4] == 28'h020_0000) return 1;
    if (a[31:8] == 24'h10_0000)  return 2;
    return -1;
  endfunction

  // Reference outcome: unmapped answers in 1 cycle with error; a slave ready after
  // 'delay' valid cycles answers in delay+2 unless it is slower than the timeout window.
  task automatic model(input vec_t v, output int lat, output int vc, output logic e, output logic [31:0] rd);
    if (decode(v.addr) < 0) begin
      lat = 1; vc = 0; e = 1'b1; rd = 32'h0;
    end else if (v.delay <= TIMEOUT - 1) begin
      lat = v.delay + 2; vc = v.delay + 1; e = v.err; rd = v.rdata;
    end else begin
      lat = TIMEOUT + 1; vc = TIMEOUT; e = 1'b1; rd = 32'h0;
    end
  endtask

  // Issue one request, act as the slaves, observe the response and compare.
  task automatic run_txn(input string name, input vec_t v);
    int          tgt;
    int          vc;
    int          lat;
    bit          bad_sel;
    bit          bad_fld;
    logic [31:0] rd_got;
    logic        e_got;
    tgt = decode(v.addr);
    vc = 0; lat = 0; bad_sel = 0; bad_fld = 0; rd_got = 'x; e_got = 1'bx;
    m_address = v.addr; m_wdata = v.wdata; m_wsel = v.wsel; m_valid = 1'b1;
    s_ready = '0; s_error = '0;
    for (int i = 0; i < 3; i++) s_rdata[32*i +: 32] = (i == tgt) ? v.rdata : ~v.rdata;
    if (v.spur) begin
      for (int i = 0; i < 3; i++) if (i != tgt) begin s_ready[i] = 1'b1; s_error[i] = 1'b1; end
    end
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (s_valid != 3'b000) begin
        vc++;
        if (tgt < 0 || s_valid != (3'b001 << tgt)) bad_sel = 1;
        if (s_address !== v.addr || s_wdata !== v.wdata || s_wsel !== v.wsel) bad_fld = 1;
      end
      if (m_ready === 1'b1) begin
        lat = k; rd_got = m_rdata; e_got = m_error;
        break;
      end
      if (tgt >= 0) begin
        s_ready[tgt] = s_valid[tgt] && (vc > v.delay);
        s_error[tgt] = v.err;
      end
    end
    if (lat == 0) begin
      errors++;
      $display("FAIL %s_no_response: got no m_ready within 60 cycles", name);
    end
    check({name, "_latency"}, lat, v.exp_lat);
    check({name, "_valid_cycles"}, vc, v.exp_v);
    check({name, "_m_error"}, {31'b0, e_got}, {31'b0, v.exp_err});
    check({name, "_m_rdata"}, rd_got, v.exp_rd);
    check({name, "_sel_onehot"}, {31'b0, bad_sel}, 32'h0);
    check({name, "_slave_fields"}, {31'b0, bad_fld}, 32'h0);
    m_valid = 1'b0; s_ready = '0; s_error = '0;
    @(posedge clk); #1;
    check({name, "_ready_pulse"}, {28'b0, m_ready, s_valid}, 32'h0);
  endtask

  initial begin
    vec_t        v;
    int          lat, vcn, r;
    logic        e;
    logic [31:0] rd;

    rst_n = 1'b0; m_address = '0; m_wdata = '0; m_wsel = '0; m_valid = 1'b0;
    s_rdata = '0; s_ready = '0; s_error = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {m_ready, m_error, s_valid, s_wsel}, 32'h0);
    check("reset_rdata", m_rdata, 32'h0);
    check("reset_s_address", s_address, 32'h0);
    rst_n = 1'b1;

    //              addr          wdata         wsel  dly rdata         err  spur lat v   e    rd
    tbl.push_back('{32'h0200_0000, 32'h0000_0100, 4'hF, 1,  32'h0,        1'b0, 0, 3,  2,  1'b0, 32'h0});
    tbl.push_back('{32'h0200_0008, 32'h0,        4'h0, 1,  32'h0000_002A, 1'b0, 0, 3,  2,  1'b0, 32'h0000_002A});
    tbl.push_back('{32'h4000_0000, 32'hDEAD_BEEF, 4'hF, 1,  32'h0000_1234, 1'b0, 1, 1,  0,  1'b1, 32'h0});
    tbl.push_back('{32'h8000_0010, 32'h0,        4'h0, 99, 32'h0000_ABCD, 1'b0, 1, 17, 16, 1'b1, 32'h0});
    tbl.push_back('{32'h8000_0020, 32'h0000_CAFE, 4'h3, 0,  32'h1111_2222, 1'b0, 0, 2,  1,  1'b0, 32'h1111_2222});
    tbl.push_back('{32'h0200_000C, 32'h0,        4'h0, 15, 32'h0000_7777, 1'b0, 0, 17, 16, 1'b0, 32'h0000_7777});
    tbl.push_back('{32'h0200_0004, 32'h0,        4'h0, 16, 32'h0000_7777, 1'b0, 0, 17, 16, 1'b1, 32'h0});
    tbl.push_back('{32'h0200_0010, 32'h0,        4'h0, 1,  32'h0000_0005, 1'b0, 0, 1,  0,  1'b1, 32'h0});
    tbl.push_back('{32'h1000_00FF, 32'h0000_00A5, 4'h1, 2,  32'h0000_00A5, 1'b0, 1, 4,  3,  1'b0, 32'h0000_00A5});
    tbl.push_back('{32'h1000_0100, 32'h0,        4'h0, 1,  32'h0000_0009, 1'b0, 0, 1,  0,  1'b1, 32'h0});
    tbl.push_back('{32'h8FFF_FFFC, 32'h2468_ACE0, 4'hC, 3,  32'h0000_1357, 1'b0, 0, 5,  4,  1'b0, 32'h0000_1357});
    tbl.push_back('{32'h9000_0000, 32'h0,        4'h0, 1,  32'h0000_0001, 1'b0, 0, 1,  0,  1'b1, 32'h0});
    tbl.push_back('{32'h1000_0004, 32'h0,        4'h0, 1,  32'h0000_0055, 1'b1, 1, 3,  2,  1'b1, 32'h0000_0055});
    foreach (tbl[i]) run_txn($sformatf("vec%0d", i), tbl[i]);

    // Reset while a timer access is stuck in WAIT.
    m_address = 32'h0200_0004; m_wdata = 32'h1234_5678; m_wsel = 4'h3; m_valid = 1'b1;
    s_ready = '0; s_error = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pre_valid", {29'b0, s_valid}, 32'h2);
    rst_n = 1'b0; m_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_ctrl", {m_ready, m_error, s_valid, s_wsel}, 32'h0);
    check("rst_mid_rdata", m_rdata, 32'h0);
    check("rst_mid_addr", s_address, 32'h0);
    check("rst_mid_wdata", s_wdata, 32'h0);
    rst_n = 1'b1; s_ready = 3'b010;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("rst_late_ready%0d", k), {28'b0, m_ready, s_valid}, 32'h0);
    end
    s_ready = '0;
    run_txn("post_reset", '{32'h0200_0004, 32'hA5A5_5A5A, 4'hF, 2, 32'h0000_0BAD, 1'b0, 0, 4, 3, 1'b0, 32'h0000_0BAD});

    // Random traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 3);
      case (r)
        0:       v.addr = {4'h8, 28'($urandom)};
        1:       v.addr = {28'h020_0000, 4'($urandom)};
        2:       v.addr = {24'h10_0000, 8'($urandom)};
        default: v.addr = $urandom;
      endcase
      v.wdata = $urandom; v.wsel = 4'($urandom);
      v.delay = $urandom_range(0, 20); v.rdata = $urandom;
      v.err = 1'($urandom); v.spur = 1'($urandom);
      model(v, lat, vcn, e, rd);
      v.exp_lat = lat; v.exp_v = vcn; v.exp_err = e; v.exp_rd = rd;
      run_txn($sformatf("rand%0d", n), v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
